// File: rtl/id_queue_pkg.sv
// Shared decode types: field encodings, the decoded bundle and RV32 opcode/funct7 constants.
package id_queue_pkg;

    typedef enum logic [2:0] {ADD_SUBf, SLLf, SLTf, SLTUf, XORf, SRL_SRAf, ORf, ANDf} func_code_t;
    typedef enum logic [2:0] {MULf, MULHf, MULHSUf, MULHUf, DIVf, DIVUf, REMf, REMUf} MUL_DIV_t;
    typedef enum logic [1:0] {BYTE, HALF, WORD, SIZE_RSVD} wrd_size_t;
    typedef enum logic [1:0] {RF2SRC0, PC2SRC0, ZERO2SRC0, SRC0_RSVD} src0sel_t;
    typedef enum logic [1:0] {RF2SRC1, IMM12_2SRC1, IMM20_2SRC1, STOFS_2SRC1} src1sel_t;
    typedef enum logic [2:0] {BEQ, BNE, BR_RSVD2, BR_RSVD3, BLT, BGE, BLTU, BGEU} br_code_t;

    typedef struct packed {
        logic       mul_div;
        logic       to_sub;
        logic       br_instr;
        logic       jal_instr;
        logic       jalr_instr;
        logic       rf_re0;
        logic       rf_re1;
        logic       rf_we;
        logic [4:0] rf_p0_addr;
        logic [4:0] rf_p1_addr;
        logic [4:0] rf_dst_addr;
        func_code_t alu_func1;
        MUL_DIV_t   alu_func2;
        wrd_size_t  word_size;
        src0sel_t   src0sel;
        src1sel_t   src1sel;
        br_code_t   br_cc;
        logic       dm_re;
        logic       dm_we;
    } dec_bundle_t;

    localparam logic [6:0] OP_REGREG = 7'b0110011;
    localparam logic [6:0] OP_REGIMM = 7'b0010011;
    localparam logic [6:0] OP_STR    = 7'b0100011;
    localparam logic [6:0] OP_LD     = 7'b0000011;
    localparam logic [6:0] OP_BR     = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;
    localparam logic [6:0] FUNCT7_MDIV = 7'h01;

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I(+M) decoder: raw instruction to decoded bundle plus illegal flag.
module rv_decode
    import id_queue_pkg::*;
#(
    parameter bit EN_MDIV = 1'b1
) (
    input  logic [31:0] instr,
    output dec_bundle_t bundle,
    output logic        illegal
);

    logic [2:0] f3;
    logic [6:0] f7;
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        bundle             = '0;
        bundle.rf_p0_addr  = instr[19:15];
        bundle.rf_p1_addr  = instr[24:20];
        bundle.rf_dst_addr = instr[11:7];
        bundle.alu_func1   = ADD_SUBf;
        bundle.alu_func2   = MULf;
        bundle.word_size   = WORD;
        bundle.src0sel     = RF2SRC0;
        bundle.src1sel     = RF2SRC1;
        illegal            = 1'b0;
        case (instr[6:0])
            OP_REGREG: begin
                bundle.rf_re0    = 1'b1;
                bundle.rf_re1    = 1'b1;
                bundle.rf_we     = 1'b1;
                bundle.alu_func1 = func_code_t'(f3);
                case (f7)
                    FUNCT7_BASE: ;
                    FUNCT7_ALT: begin
                        if (f3 == 3'b000 || f3 == 3'b101) bundle.to_sub = 1'b1;
                        else illegal = 1'b1;
                    end
                    FUNCT7_MDIV: begin
                        if (EN_MDIV) begin
                            bundle.mul_div   = 1'b1;
                            bundle.alu_func2 = MUL_DIV_t'(f3);
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                bundle.rf_re0    = 1'b1;
                bundle.rf_we     = 1'b1;
                bundle.src1sel   = IMM12_2SRC1;
                bundle.alu_func1 = func_code_t'(f3);
                // shift-immediates reuse funct7 bits; bit 30 picks arithmetic right shift
                if (f3 == 3'b001 && f7 != FUNCT7_BASE) illegal = 1'b1;
                if (f3 == 3'b101) begin
                    bundle.to_sub = instr[30];
                    if (f7 != FUNCT7_BASE && f7 != FUNCT7_ALT) illegal = 1'b1;
                end
            end
            OP_STR: begin
                bundle.rf_re0    = 1'b1;
                bundle.rf_re1    = 1'b1;
                bundle.dm_we     = 1'b1;
                bundle.src1sel   = STOFS_2SRC1;
                bundle.word_size = wrd_size_t'(f3[1:0]);
                if (f3 > 3'd2) illegal = 1'b1;
            end
            OP_LD: begin
                bundle.rf_re0    = 1'b1;
                bundle.rf_we     = 1'b1;
                bundle.dm_re     = 1'b1;
                bundle.src1sel   = IMM12_2SRC1;
                bundle.word_size = wrd_size_t'(f3[1:0]);
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) illegal = 1'b1;
            end
            OP_BR: begin
                bundle.rf_re0   = 1'b1;
                bundle.rf_re1   = 1'b1;
                bundle.br_instr = 1'b1;
                bundle.br_cc    = br_code_t'(f3);
                if (f3 == 3'd2 || f3 == 3'd3) illegal = 1'b1;
            end
            OP_JAL: begin
                bundle.jal_instr = 1'b1;
                bundle.rf_we     = 1'b1;
                bundle.src0sel   = PC2SRC0;
                bundle.src1sel   = IMM20_2SRC1;
            end
            OP_JALR: begin
                bundle.jalr_instr = 1'b1;
                bundle.rf_re0     = 1'b1;
                bundle.rf_we      = 1'b1;
                bundle.src1sel    = IMM12_2SRC1;
                if (f3 != 3'd0) illegal = 1'b1;
            end
            OP_AUIPC: begin
                bundle.rf_we   = 1'b1;
                bundle.src0sel = PC2SRC0;
                bundle.src1sel = IMM20_2SRC1;
            end
            OP_LUI: begin
                bundle.rf_we   = 1'b1;
                bundle.src0sel = ZERO2SRC0;
                bundle.src1sel = IMM20_2SRC1;
            end
            default: illegal = 1'b1;
        endcase
        // illegal entries must have no architectural side effects downstream
        if (illegal) begin
            bundle.rf_we      = 1'b0;
            bundle.dm_re      = 1'b0;
            bundle.dm_we      = 1'b0;
            bundle.br_instr   = 1'b0;
            bundle.jal_instr  = 1'b0;
            bundle.jalr_instr = 1'b0;
        end
        if (bundle.rf_dst_addr == 5'd0) bundle.rf_we = 1'b0;
    end

endmodule

// File: rtl/id_queue.sv
// Decode stage: decodes fetched instructions and buffers DEPTH decoded bundles for execute.
module id_queue
    import id_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32,
    parameter bit EN_MDIV = 1'b1,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [XLEN-1:0]  out_pc,
    output dec_bundle_t      out_bundle,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    dec_bundle_t                  in_bundle;
    logic                         in_illegal;
    dec_bundle_t [DEPTH-1:0]      bun_q;
    logic [DEPTH-1:0][XLEN-1:0]   pc_q;
    logic [DEPTH-1:0]             ill_q;
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;
    logic                         push, pop;

    rv_decode #(.EN_MDIV(EN_MDIV)) u_dec (
        .instr   (in_instr),
        .bundle  (in_bundle),
        .illegal (in_illegal)
    );

    // explicit wrap so DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_rdy  = (count < CNT_W'(DEPTH));
    assign out_vld = (count != '0);
    assign push    = in_vld & in_rdy & ~flush;
    assign pop     = out_vld & out_rdy & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            bun_q  <= '0;
            pc_q   <= '0;
            ill_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                bun_q[wr_ptr] <= in_bundle;
                pc_q[wr_ptr]  <= in_pc;
                ill_q[wr_ptr] <= in_illegal;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    assign out_bundle  = out_vld ? bun_q[rd_ptr] : '0;
    assign out_pc      = out_vld ? pc_q[rd_ptr]  : '0;
    assign out_illegal = out_vld & ill_q[rd_ptr];

endmodule

// File: tb/tb_id_queue.sv
// Bench for id_queue: directed scenarios then random traffic against a queue-based reference.
module tb_id_queue;
    import id_queue_pkg::*;

    localparam int DEPTH   = 4;
    localparam int XLEN    = 32;
    localparam bit EN_MDIV = 1'b1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic             clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic             in_vld = 1'b0, out_rdy = 1'b0;
    logic [31:0]      in_instr = '0;
    logic [XLEN-1:0]  in_pc = '0;
    logic             in_rdy, out_vld, out_illegal;
    logic [XLEN-1:0]  out_pc;
    dec_bundle_t      out_bundle;
    logic [CNT_W-1:0] count;

    id_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .EN_MDIV(EN_MDIV)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_pc(out_pc), .out_bundle(out_bundle), .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        dec_bundle_t     b;
        logic            ill;
    } ment_t;

    ment_t mq[$];
    int    npass = 0, ntot = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference decode written as per-field rules over opcode classes
    function automatic void m_decode(input logic [31:0] i, output dec_bundle_t b, output logic ill);
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic rr, ri, st, ld, br, jal, jalr, aui, lui;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        rr = op == OP_REGREG; ri = op == OP_REGIMM; st = op == OP_STR; ld = op == OP_LD;
        br = op == OP_BR; jal = op == OP_JAL; jalr = op == OP_JALR; aui = op == OP_AUIPC; lui = op == OP_LUI;
        ill = !(rr | ri | st | ld | br | jal | jalr | aui | lui)
            | (rr && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 7'h01 && EN_MDIV)))
            | (ri && f3 == 1 && f7 != 7'h00)
            | (ri && f3 == 5 && f7 != 7'h00 && f7 != 7'h20)
            | (st && f3 > 2) | (ld && (f3 == 3 || f3 >= 6))
            | (br && (f3 == 2 || f3 == 3)) | (jalr && f3 != 0);
        b = '0;
        b.rf_p0_addr  = i[19:15];
        b.rf_p1_addr  = i[24:20];
        b.rf_dst_addr = i[11:7];
        b.rf_re0      = rr | ri | st | ld | br | jalr;
        b.rf_re1      = rr | st | br;
        b.rf_we       = (rr | ri | ld | jal | jalr | aui | lui) && !ill && i[11:7] != 0;
        b.mul_div     = rr && f7 == 7'h01 && EN_MDIV;
        b.to_sub      = (rr && f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (ri && f3 == 5 && i[30]);
        b.alu_func1   = (rr | ri) ? func_code_t'(f3) : ADD_SUBf;
        b.alu_func2   = b.mul_div ? MUL_DIV_t'(f3) : MULf;
        b.word_size   = (st | ld) ? wrd_size_t'(f3[1:0]) : WORD;
        b.src0sel     = (jal | aui) ? PC2SRC0 : lui ? ZERO2SRC0 : RF2SRC0;
        b.src1sel     = (ri | ld | jalr) ? IMM12_2SRC1 : st ? STOFS_2SRC1 :
                        (jal | aui | lui) ? IMM20_2SRC1 : RF2SRC1;
        b.br_cc       = br ? br_code_t'(f3) : BEQ;
        b.br_instr    = br && !ill;
        b.jal_instr   = jal;
        b.jalr_instr  = jalr && !ill;
        b.dm_re       = ld && !ill;
        b.dm_we       = st && !ill;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 64'(count), 64'(mq.size()));
        chk({tag, "_out_vld"}, 64'(out_vld), 64'(mq.size() != 0));
        chk({tag, "_in_rdy"}, 64'(in_rdy), 64'(mq.size() < DEPTH));
        if (mq.size() != 0) begin
            chk({tag, "_bundle"}, 64'(out_bundle), 64'(mq[0].b));
            chk({tag, "_pc"}, 64'(out_pc), 64'(mq[0].pc));
            chk({tag, "_ill"}, 64'(out_illegal), 64'(mq[0].ill));
        end else begin
            chk({tag, "_bundle0"}, 64'(out_bundle), 64'd0);
            chk({tag, "_pc0"}, 64'(out_pc), 64'd0);
            chk({tag, "_ill0"}, 64'(out_illegal), 64'd0);
        end
    endtask

    // One clock: reference decides push/pop from its own occupancy, then both advance
    task automatic cycle(input string tag);
        bit do_push, do_pop;
        ment_t e;
        do_push = in_vld && mq.size() < DEPTH && !flush;
        do_pop  = mq.size() != 0 && out_rdy && !flush;
        e.pc = in_pc;
        m_decode(in_instr, e.b, e.ill);
        @(posedge clk);
        #1;
        if (flush) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        check_state(tag);
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc, input string tag);
        in_vld = 1'b1; in_instr = ins; in_pc = pc;
        cycle(tag);
        in_vld = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 10))
            0: r[6:0] = OP_REGREG;  1: r[6:0] = OP_REGIMM;  2: r[6:0] = OP_STR;
            3: r[6:0] = OP_LD;      4: r[6:0] = OP_BR;      5: r[6:0] = OP_JAL;
            6: r[6:0] = OP_JALR;    7: r[6:0] = OP_AUIPC;   8: r[6:0] = OP_LUI;
            9: r[6:0] = OP_REGREG;  default: ;
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;  1: r[31:25] = 7'h20;  2: r[31:25] = 7'h01;  default: ;
        endcase
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    initial begin
        // reset
        #12;
        check_state("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_state("rst_rel");

        // 1: ADD x3,x1,x2
        out_rdy = 1'b1;
        push(32'h002081B3, 32'h100, "s1_push");
        chk("s1_vld", 64'(out_vld), 64'd1);
        chk("s1_p0", 64'(out_bundle.rf_p0_addr), 64'd1);
        chk("s1_p1", 64'(out_bundle.rf_p1_addr), 64'd2);
        chk("s1_dst", 64'(out_bundle.rf_dst_addr), 64'd3);
        chk("s1_we", 64'(out_bundle.rf_we), 64'd1);
        chk("s1_sub", 64'(out_bundle.to_sub), 64'd0);
        chk("s1_pc", 64'(out_pc), 64'h100);
        cycle("s1_pop");
        chk("s1_cnt0", 64'(count), 64'd0);

        // 2: SUB, SRAI, MUL
        out_rdy = 1'b0;
        push(32'h402081B3, 32'h200, "s2_sub");
        push(32'h40315093, 32'h204, "s2_srai");
        push(32'h027302B3, 32'h208, "s2_mul");
        chk("s2_sub_tosub", 64'(out_bundle.to_sub), 64'd1);
        out_rdy = 1'b1;
        cycle("s2_pop0");
        chk("s2_srai_tosub", 64'(out_bundle.to_sub), 64'd1);
        chk("s2_srai_src1", 64'(out_bundle.src1sel), 64'(IMM12_2SRC1));
        cycle("s2_pop1");
        chk("s2_mul_md", 64'(out_bundle.mul_div), 64'd1);
        chk("s2_mul_ill", 64'(out_illegal), 64'd0);
        cycle("s2_pop2");

        // 3: all-zero word and ADDI x0,x0,0
        out_rdy = 1'b0;
        push(32'h00000000, 32'h300, "s3_zero");
        push(32'h00000013, 32'h304, "s3_nop");
        chk("s3_zero_ill", 64'(out_illegal), 64'd1);
        chk("s3_zero_en", 64'({out_bundle.rf_we, out_bundle.dm_re, out_bundle.dm_we,
            out_bundle.br_instr, out_bundle.jal_instr, out_bundle.jalr_instr}), 64'd0);
        out_rdy = 1'b1;
        cycle("s3_pop0");
        chk("s3_nop_ill", 64'(out_illegal), 64'd0);
        chk("s3_nop_we", 64'(out_bundle.rf_we), 64'd0);
        cycle("s3_pop1");

        // 4: fill, overfill, drain with input held
        out_rdy = 1'b0;
        for (int k = 0; k < DEPTH; k++) push(32'h00000093 | (32'(k + 1) << 7), 32'h400 + 32'(4 * k), "s4_fill");
        chk("s4_full_cnt", 64'(count), 64'(DEPTH));
        chk("s4_full_rdy", 64'(in_rdy), 64'd0);
        in_vld = 1'b1; in_instr = 32'h00A00513; in_pc = 32'h4F0;
        cycle("s4_over");
        out_rdy = 1'b1;
        cycle("s4_first_pop");
        chk("s4_rdy_after_pop", 64'(in_rdy), 64'd1);
        for (int k = 0; k < 3; k++) cycle("s4_stream");
        in_vld = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) cycle("s4_drain");

        // 5: flush with simultaneous push and pop
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) push(32'h00208033 | (32'(k + 5) << 7), 32'h500 + 32'(4 * k), "s5_fill");
        chk("s5_cnt3", 64'(count), 64'd3);
        flush = 1'b1; in_vld = 1'b1; out_rdy = 1'b1; in_instr = 32'h00100093; in_pc = 32'h5F0;
        cycle("s5_flush");
        chk("s5_cnt0", 64'(count), 64'd0);
        chk("s5_vld0", 64'(out_vld), 64'd0);
        flush = 1'b0; in_vld = 1'b0;
        cycle("s5_after");

        // 6: asynchronous reset mid-clock
        out_rdy = 1'b0;
        push(32'h002081B3, 32'h600, "s6_a");
        push(32'h402081B3, 32'h604, "s6_b");
        chk("s6_cnt2", 64'(count), 64'd2);
        #3 rst_n = 1'b0;
        #1;
        mq.delete();
        chk("s6_rst_vld", 64'(out_vld), 64'd0);
        chk("s6_rst_cnt", 64'(count), 64'd0);
        #2 rst_n = 1'b1;
        out_rdy = 1'b1;
        push(32'h002081B3, 32'h100, "s6_push");
        chk("s6_pc", 64'(out_pc), 64'h100);
        chk("s6_dst", 64'(out_bundle.rf_dst_addr), 64'd3);
        cycle("s6_pop");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            in_vld   = 1'($urandom_range(0, 1));
            out_rdy  = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 31) == 0);
            in_instr = rand_instr();
            in_pc    = $urandom();
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/id_queue.md
Name: id_queue

Overview:
- Decode stage with a DEPTH-entry decoded-instruction buffer between fetch and execute.
- Accepts raw RV32 instructions with their PC over a valid/ready handshake, decodes them, and queues the decoded bundles.
- Presents the head bundle to execute over a second valid/ready handshake.
- Adds illegal-instruction detection, an optional M extension, SRAI subtract flagging, x0-write suppression and pipeline flush.

Parameters:
DEPTH, 4, number of buffered decoded entries (>=2; need not be a power of 2)
XLEN, 32, PC width
EN_MDIV, 1, 1 = MUL/DIV legal; 0 = funct7 0x01 on REGREG is decoded as illegal
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all buffered entries (branch mispredict / trap)
in_vld  in  1  fetch has an instruction
in_rdy  out  1  queue can accept an instruction
in_instr  in  32  raw instruction
in_pc  in  XLEN  PC of in_instr
out_vld  out  1  head entry valid
out_rdy  in  1  execute consumes head
out_pc  out  XLEN  head PC
out_bundle  out  dec_bundle_t  head decoded fields: mul_div, to_sub, br_instr, jal_instr, jalr_instr, rf_re0/1, rf_we, rf_p0/p1/dst_addr, alu_func1, alu_func2, word_size, src0sel, src1sel, br_cc, dm_re, dm_we
out_illegal  out  1  head instruction is illegal
count  out  CNT_W  current occupancy

Behaviour:
- Reset (rst_n low, async): wr_ptr = rd_ptr = count = 0, out_vld = 0, all stored entries cleared to 0. out_bundle/out_pc/out_illegal = 0. in_rdy = 1 once rst_n is high.
- in_rdy = (count < DEPTH). It does not depend on out_rdy, so a pop in the same cycle does not free space for a push.
- Push when in_vld & in_rdy & !flush: the decode of in_instr/in_pc is written at wr_ptr on the clock edge.
- Pop when out_vld & out_rdy & !flush: rd_ptr advances.
- Pointers wrap from DEPTH-1 to 0 explicitly.
- count: +1 on push only, -1 on pop only, unchanged on push & pop.
- Latency: an instruction accepted at edge N is visible at out_vld/out_bundle after edge N (cycle N+1). There is no combinational in->out path.
- out_vld = (count != 0). Head outputs are driven from entry[rd_ptr]; all head outputs are forced to 0 when out_vld = 0.
- Flush takes priority: on the edge it is sampled, pointers and count go to 0 and any same-cycle push or pop is discarded. out_vld = 0 the cycle after.
- Full (count == DEPTH): in_rdy = 0; in_vld is ignored.
- Empty: out_rdy is ignored.
- Decode defaults: rf_p0 = instr[19:15], rf_p1 = instr[24:20], rf_dst = instr[11:7], alu_func1 = ADD_SUBf, alu_func2 = MULf, word_size = WORD, src0sel = RF2SRC0, src1sel = RF2SRC1, everything else 0.
- Decode per opcode: REGREG, REGIMM, STR, LD, BR, JAL, JALR, AUIPC and LUI are decoded per the common package encodings.
- REGIMM with funct3 = 101: to_sub = instr[30] (SRAI vs SRLI).
- Illegal when any of the following holds:
  - opcode not in the set above;
  - REGREG funct7 not in {0x00, 0x20 (funct3 000/101 only), 0x01 (EN_MDIV = 1 only)};
  - REGIMM funct3 001 with funct7 != 0x00;
  - REGIMM funct3 101 with funct7 not in {0x00, 0x20};
  - STR funct3 > 2;
  - LD funct3 in {3, 6, 7};
  - BR funct3 in {2, 3};
  - JALR funct3 != 0.
- Illegal entries: illegal = 1; rf_we, dm_re, dm_we, br_instr, jal_instr and jalr_instr forced to 0. The entry still occupies a slot and pops normally.
- rf_we is forced to 0 whenever rf_dst_addr == 0, for all opcodes.
- Reset asserted mid-operation: contents are dropped immediately and asynchronously; no partial entry survives.

Decomposition:
- Shared package (common): dec_bundle_t packed struct, built from the existing func_code_t, MUL_DIV_t, wrd_size_t, src0sel_t, src1sel_t and br_code_t.
- Also in the package: FUNCT7_BASE = 7'h00, FUNCT7_ALT = 7'h20, FUNCT7_MDIV = 7'h01.
- Sub-module rv_decode (combinational, parameter EN_MDIV): instr -> dec_bundle_t + illegal.
- id_queue instantiates rv_decode on the input side and holds the storage, pointers and handshake logic.

Test Plan:
1. Reset, then push 0x002081B3 (ADD x3,x1,x2) at pc 0x100, out_rdy = 1 -> next cycle out_vld = 1, rf_p0 = 1, rf_p1 = 2, rf_dst = 3, rf_we = 1, to_sub = 0, out_pc = 0x100; count returns to 0 after the pop.
2. Push 0x402081B3 (SUB), 0x40315093 (SRAI x1,x2,3) and 0x027302B3 (MUL x5,x6,x7) -> to_sub = 1; then to_sub = 1 with src1sel = IMM12_2SRC1; then mul_div = 1 with EN_MDIV = 1, or illegal = 1 and rf_we = 0 with EN_MDIV = 0.
3. Push 0x00000000 and 0x00000013 (ADDI x0,x0,0) -> first entry illegal = 1 with all enables 0; second illegal = 0 with rf_we = 0.
4. out_rdy = 0, push DEPTH = 4 instructions -> count = 4, in_rdy = 0. A 5th in_vld is ignored. Then out_rdy = 1 with in_vld held -> in_rdy = 1 the cycle after the first pop, and entries drain in FIFO order with correct pointer wrap.
5. count = 3, flush asserted with in_vld = 1 and out_rdy = 1 -> next cycle count = 0 and out_vld = 0; the flushed-cycle push never appears at the output.
6. Drop rst_n asynchronously mid-clock while count = 2 -> out_vld = 0 and count = 0 immediately; after release a push behaves as in scenario 1.
